// File: rtl/std_nbdcache_tag_array.sv
// rtl/std_nbdcache_tag_array.sv - multi-way {valid, tag} store with self-init, flush and way-parallel compare
// Holds a behavioural single-port tc_sram_impl (1-cycle read) used once per way.
module tc_sram_impl #(
  parameter int unsigned NumWords  = 256,
  parameter int unsigned DataWidth = 45,
  parameter              SimInit   = "none",
  parameter int unsigned AddrWidth = $clog2(NumWords)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [DataWidth-1:0] wdata_i,
  output logic [DataWidth-1:0] rdata_o
);
  // Any SimInit other than "none" gives a deterministic read register after reset
  localparam bit ZeroRdata = (SimInit != "none");

  logic [DataWidth-1:0] mem_q [NumWords];
  logic [DataWidth-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (req_i && we_i) mem_q[addr_i] <= wdata_i;
    if (rst_i && ZeroRdata) rdata_q <= '0;
    else if (req_i && !we_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;
endmodule

module std_nbdcache_tag_array #(
  parameter int unsigned NumWords  = 256,
  parameter int unsigned TagWidth  = 44,
  parameter int unsigned WayCount  = 4,
  parameter int unsigned Latency   = 1,
  parameter              SimInit   = "none",
  parameter int unsigned AddrWidth = $clog2(NumWords)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  output logic                         busy_o,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic                         req_we_i,
  input  logic [WayCount-1:0]          req_way_i,
  input  logic [AddrWidth-1:0]         req_addr_i,
  input  logic [TagWidth-1:0]          req_tag_i,
  input  logic                         req_vld_i,
  output logic                         rsp_valid_o,
  output logic                         rsp_hit_o,
  output logic [WayCount-1:0]          rsp_hit_way_o,
  output logic                         rsp_multi_hit_o,
  output logic [WayCount-1:0]          rsp_vld_o,
  output logic [WayCount*TagWidth-1:0] rsp_tag_o
);
  localparam int unsigned EntryWidth = TagWidth + 1;
  localparam logic [AddrWidth-1:0] LastSet = AddrWidth'(NumWords - 1);

  typedef enum logic {S_INIT, S_IDLE} state_e;

  state_e                         state_q, state_d;
  logic [AddrWidth-1:0]           set_cnt_q, set_cnt_d;
  logic [WayCount-1:0]            sram_req;
  logic                           sram_we;
  logic [AddrWidth-1:0]           sram_addr;
  logic [EntryWidth-1:0]          sram_wdata;
  logic [WayCount*EntryWidth-1:0] sram_rdata;
  logic                           lookup_acc;

  always_comb begin
    state_d     = state_q;
    set_cnt_d   = set_cnt_q;
    busy_o      = 1'b0;
    req_ready_o = 1'b0;
    sram_req    = '0;
    sram_we     = 1'b0;
    sram_addr   = req_addr_i;
    sram_wdata  = {req_vld_i, req_tag_i};
    lookup_acc  = 1'b0;
    case (state_q)
      S_INIT: begin
        busy_o     = 1'b1;
        sram_req   = '1;
        sram_we    = 1'b1;
        sram_addr  = set_cnt_q;
        sram_wdata = '0;
        set_cnt_d  = set_cnt_q + 1'b1;
        if (flush_i) begin
          set_cnt_d = '0;
        end else if (set_cnt_q == LastSet) begin
          state_d   = S_IDLE;
          set_cnt_d = '0;
        end
      end
      S_IDLE: begin
        // A flush in the same cycle as a request wins; the request is not taken
        req_ready_o = !flush_i;
        if (flush_i) begin
          state_d   = S_INIT;
          set_cnt_d = '0;
        end else if (req_valid_i) begin
          if (req_we_i) begin
            sram_req = req_way_i;
            sram_we  = 1'b1;
          end else begin
            sram_req   = '1;
            lookup_acc = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  for (genvar w = 0; w < WayCount; w++) begin : g_way
    tc_sram_impl #(
      .NumWords  (NumWords),
      .DataWidth (EntryWidth),
      .SimInit   (SimInit)
    ) i_sram (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .req_i   (sram_req[w]),
      .we_i    (sram_we),
      .addr_i  (sram_addr),
      .wdata_i (sram_wdata),
      .rdata_o (sram_rdata[w*EntryWidth +: EntryWidth])
    );
  end

  // Extra latency stages: rdata and the compare tag/valid move in lockstep
  logic [Latency-1:0]             pipe_vld_q, pipe_vld_d;
  logic [TagWidth-1:0]            pipe_tag_q [Latency];
  logic [TagWidth-1:0]            pipe_tag_d [Latency];
  logic [WayCount*EntryWidth-1:0] rd_pipe_q [Latency];
  logic [WayCount*EntryWidth-1:0] rd_pipe_d [Latency];
  logic [WayCount*EntryWidth-1:0] rd_fin;

  always_comb begin
    pipe_vld_d[0] = lookup_acc;
    pipe_tag_d[0] = req_tag_i;
    rd_pipe_d[0]  = sram_rdata;
    for (int s = 1; s < Latency; s++) begin
      pipe_vld_d[s] = pipe_vld_q[s-1];
      pipe_tag_d[s] = pipe_tag_q[s-1];
      rd_pipe_d[s]  = rd_pipe_q[s-1];
    end
    rd_fin = sram_rdata;
    for (int s = 0; s < Latency - 1; s++) rd_fin = rd_pipe_q[s];
  end

  logic                         live_hit, live_multi;
  logic [WayCount-1:0]          live_hit_way, live_vld;
  logic [WayCount*TagWidth-1:0] live_tag;

  always_comb begin
    live_hit     = 1'b0;
    live_multi   = 1'b0;
    live_hit_way = '0;
    live_vld     = '0;
    live_tag     = '0;
    for (int w = 0; w < WayCount; w++) begin
      live_vld[w]                      = rd_fin[w*EntryWidth + TagWidth];
      live_tag[w*TagWidth +: TagWidth] = rd_fin[w*EntryWidth +: TagWidth];
      if (live_vld[w] && (live_tag[w*TagWidth +: TagWidth] == pipe_tag_q[Latency-1])) begin
        if (live_hit) live_multi = 1'b1;
        else live_hit_way[w] = 1'b1;
        live_hit = 1'b1;
      end
    end
  end

  // Response fields hold their last delivered value between responses
  logic                         hit_q, multi_q;
  logic [WayCount-1:0]          hit_way_q, vld_q;
  logic [WayCount*TagWidth-1:0] tag_q;

  assign rsp_valid_o     = pipe_vld_q[Latency-1];
  assign rsp_hit_o       = rsp_valid_o ? live_hit     : hit_q;
  assign rsp_hit_way_o   = rsp_valid_o ? live_hit_way : hit_way_q;
  assign rsp_multi_hit_o = rsp_valid_o ? live_multi   : multi_q;
  assign rsp_vld_o       = rsp_valid_o ? live_vld     : vld_q;
  assign rsp_tag_o       = rsp_valid_o ? live_tag     : tag_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_INIT;
      set_cnt_q  <= '0;
      pipe_vld_q <= '0;
      hit_q      <= 1'b0;
      multi_q    <= 1'b0;
      hit_way_q  <= '0;
      vld_q      <= '0;
      tag_q      <= '0;
    end else begin
      state_q    <= state_d;
      set_cnt_q  <= set_cnt_d;
      pipe_vld_q <= pipe_vld_d;
      hit_q      <= rsp_hit_o;
      multi_q    <= rsp_multi_hit_o;
      hit_way_q  <= rsp_hit_way_o;
      vld_q      <= rsp_vld_o;
      tag_q      <= rsp_tag_o;
    end
  end

  always_ff @(posedge clk_i) begin
    pipe_tag_q <= pipe_tag_d;
    rd_pipe_q  <= rd_pipe_d;
  end
endmodule

// File: tb/tb_std_nbdcache_tag_array.sv
// tb/tb_std_nbdcache_tag_array.sv - table-driven and randomized bench for the tag array
module tb_std_nbdcache_tag_array;
  localparam int NW = 16, TW = 20, WC = 4, LAT = 2, AW = 4;

  logic           clk_i = 1'b0;
  logic           rst_i, flush_i, req_valid_i, req_we_i, req_vld_i;
  logic [WC-1:0]  req_way_i;
  logic [AW-1:0]  req_addr_i;
  logic [TW-1:0]  req_tag_i;
  logic           busy_o, req_ready_o, rsp_valid_o, rsp_hit_o, rsp_multi_hit_o;
  logic [WC-1:0]  rsp_hit_way_o, rsp_vld_o;
  logic [WC*TW-1:0] rsp_tag_o;

  std_nbdcache_tag_array #(
    .NumWords (NW), .TagWidth (TW), .WayCount (WC), .Latency (LAT), .SimInit ("none")
  ) dut (
    .clk_i (clk_i), .rst_i (rst_i), .flush_i (flush_i), .busy_o (busy_o),
    .req_valid_i (req_valid_i), .req_ready_o (req_ready_o), .req_we_i (req_we_i),
    .req_way_i (req_way_i), .req_addr_i (req_addr_i), .req_tag_i (req_tag_i),
    .req_vld_i (req_vld_i), .rsp_valid_o (rsp_valid_o), .rsp_hit_o (rsp_hit_o),
    .rsp_hit_way_o (rsp_hit_way_o), .rsp_multi_hit_o (rsp_multi_hit_o),
    .rsp_vld_o (rsp_vld_o), .rsp_tag_o (rsp_tag_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    bit we; logic [3:0] way; int addr; logic [TW-1:0] tag; bit vld;
    bit hit; logic [3:0] hw; bit multi; logic [3:0] ev;
  } vec_t;

  typedef struct {
    int due; bit hit; logic [3:0] hw; bit multi; logic [3:0] vld; logic [WC*TW-1:0] tags;
    bit tab_en; vec_t t;
  } exp_t;

  int checks = 0, errors = 0;
  bit           m_vld [NW][WC];
  logic [TW-1:0] m_tag [NW][WC];
  exp_t exp_q[$];
  exp_t me;
  vec_t tab[12];
  vec_t nov;
  bit            last_hit, last_multi;
  logic [3:0]    last_hw, last_vld;
  logic [WC*TW-1:0] last_tags;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < NW; s++)
      for (int w = 0; w < WC; w++) begin
        m_vld[s][w] = 1'b0;
        m_tag[s][w] = '0;
      end
  endtask

  function automatic exp_t model_lookup(input int addr, input logic [TW-1:0] tag);
    exp_t e;
    int hits[$];
    e.tags = '0;
    e.vld  = '0;
    for (int w = 0; w < WC; w++) begin
      e.vld[w] = m_vld[addr][w];
      e.tags[w*TW +: TW] = m_tag[addr][w];
      if (m_vld[addr][w] && m_tag[addr][w] == tag) hits.push_back(w);
    end
    e.hit   = hits.size() > 0;
    e.hw    = (hits.size() > 0) ? 4'(1 << hits[0]) : 4'b0000;
    e.multi = hits.size() > 1;
    return e;
  endfunction

  task automatic issue(input bit we, input logic [3:0] way, input int addr,
                       input logic [TW-1:0] tag, input bit vld, input bit tab_en, input vec_t v);
    exp_t e;
    req_valid_i = 1'b1; req_we_i = we; req_way_i = way;
    req_addr_i = addr[AW-1:0]; req_tag_i = tag; req_vld_i = vld;
    if (we) begin
      for (int w = 0; w < WC; w++)
        if (way[w]) begin
          m_vld[addr][w] = vld;
          m_tag[addr][w] = tag;
        end
    end else begin
      e = model_lookup(addr, tag);
      e.due = cyc + LAT;
      e.tab_en = tab_en;
      e.t = v;
      exp_q.push_back(e);
    end
    @(negedge clk_i);
    check("req_ready", req_ready_o, 1);
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic count_busy(input string name);
    int n = 0;
    bit done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk_i);
      if (busy_o) begin
        n++;
        check("ready_in_init", req_ready_o, 0);
      end else done = 1;
    end
    check(name, n, NW);
    check("ready_after_init", req_ready_o, 1);
    @(posedge clk_i); #1;
  endtask

  always @(negedge clk_i) begin
    if (rsp_valid_o) begin
      if (exp_q.size() == 0) check("unexpected_rsp", 1, 0);
      else begin
        me = exp_q.pop_front();
        check("rsp_cycle", cyc, me.due);
        check("rsp_hit", rsp_hit_o, me.hit);
        check("rsp_hit_way", rsp_hit_way_o, me.hw);
        check("rsp_multi_hit", rsp_multi_hit_o, me.multi);
        check("rsp_vld", rsp_vld_o, me.vld);
        check("rsp_tag", rsp_tag_o, me.tags);
        if (me.tab_en) begin
          check("tab_hit", rsp_hit_o, me.t.hit);
          check("tab_hit_way", rsp_hit_way_o, me.t.hw);
          check("tab_multi", rsp_multi_hit_o, me.t.multi);
          check("tab_vld", rsp_vld_o, me.t.ev);
        end
        last_hit = me.hit; last_hw = me.hw; last_multi = me.multi;
        last_vld = me.vld; last_tags = me.tags;
      end
    end else begin
      check("hold_tag", rsp_tag_o, last_tags);
      check("hold_hit_way", rsp_hit_way_o, last_hw);
      check("hold_flags", {rsp_hit_o, rsp_multi_hit_o, rsp_vld_o}, {last_hit, last_multi, last_vld});
      if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
        check("missing_rsp", 0, 1);
        void'(exp_q.pop_front());
      end
    end
    if (rst_i) begin
      last_hit = 0; last_hw = '0; last_multi = 0; last_vld = '0; last_tags = '0;
    end
  end

  initial begin
    logic [TW-1:0] t;
    int a, r;
    last_hit = 0; last_hw = '0; last_multi = 0; last_vld = '0; last_tags = '0;
    rst_i = 1; flush_i = 0; req_valid_i = 0; req_we_i = 0; req_vld_i = 0;
    req_way_i = '0; req_addr_i = '0; req_tag_i = '0;
    nov = '{we:0, way:0, addr:0, tag:0, vld:0, hit:0, hw:0, multi:0, ev:0};
    tab[0]  = '{we:1, way:4'b0100, addr:5,  tag:20'hABCDE, vld:1, hit:0, hw:4'b0000, multi:0, ev:4'b0000};
    tab[1]  = '{we:0, way:4'b0000, addr:5,  tag:20'hABCDE, vld:0, hit:1, hw:4'b0100, multi:0, ev:4'b0100};
    tab[2]  = '{we:0, way:4'b0000, addr:5,  tag:20'hABCDF, vld:0, hit:0, hw:4'b0000, multi:0, ev:4'b0100};
    tab[3]  = '{we:1, way:4'b1001, addr:9,  tag:20'h12345, vld:1, hit:0, hw:4'b0000, multi:0, ev:4'b0000};
    tab[4]  = '{we:0, way:4'b0000, addr:9,  tag:20'h12345, vld:0, hit:1, hw:4'b0001, multi:1, ev:4'b1001};
    tab[5]  = '{we:1, way:4'b0010, addr:7,  tag:20'h11111, vld:0, hit:0, hw:4'b0000, multi:0, ev:4'b0000};
    tab[6]  = '{we:0, way:4'b0000, addr:7,  tag:20'h11111, vld:0, hit:0, hw:4'b0000, multi:0, ev:4'b0000};
    tab[7]  = '{we:0, way:4'b0000, addr:5,  tag:20'h00000, vld:0, hit:0, hw:4'b0000, multi:0, ev:4'b0100};
    tab[8]  = '{we:1, way:4'b1111, addr:15, tag:20'hFFFFF, vld:1, hit:0, hw:4'b0000, multi:0, ev:4'b0000};
    tab[9]  = '{we:0, way:4'b0000, addr:15, tag:20'hFFFFF, vld:0, hit:1, hw:4'b0001, multi:1, ev:4'b1111};
    tab[10] = '{we:1, way:4'b1000, addr:0,  tag:20'h00000, vld:1, hit:0, hw:4'b0000, multi:0, ev:4'b0000};
    tab[11] = '{we:0, way:4'b0000, addr:0,  tag:20'h00000, vld:0, hit:1, hw:4'b1000, multi:0, ev:4'b1000};
    model_clear();

    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("rst_busy", busy_o, 1);
    check("rst_ready", req_ready_o, 0);
    check("rst_rsp", {rsp_valid_o, rsp_hit_o, rsp_hit_way_o, rsp_multi_hit_o, rsp_vld_o, rsp_tag_o}, 0);
    @(posedge clk_i); #1;
    rst_i = 0;
    count_busy("init_busy_cycles");

    for (int s = 0; s < NW; s++) issue(0, 4'b0000, s, 20'h0, 0, 0, nov);
    for (int i = 0; i < 12; i++)
      issue(tab[i].we, tab[i].way, tab[i].addr, tab[i].tag, tab[i].vld, !tab[i].we, tab[i]);

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      a = $urandom_range(0, NW - 1);
      t = 20'h50000 + 20'($urandom_range(0, 3));
      if (r < 4) issue(1, 4'($urandom_range(0, 15)), a, t, $urandom_range(0, 3) != 0, 0, nov);
      else if (r < 9) issue(0, 4'b0000, a, t, 0, 0, nov);
      else begin @(posedge clk_i); #1; end
    end

    for (int s = 0; s < NW; s++) issue(0, 4'b0000, s, 20'h50001, 0, 0, nov);
    issue(0, 4'b0000, 3, 20'h50002, 0, 0, nov);
    issue(0, 4'b0000, 9, 20'h12345, 0, 0, nov);
    flush_i = 1;
    model_clear();
    @(posedge clk_i); #1;
    flush_i = 0;
    count_busy("flush_busy_cycles");
    for (int s = 0; s < NW; s++) issue(0, 4'b0000, s, 20'h0, 0, 0, nov);
    repeat (LAT + 1) begin @(posedge clk_i); #1; end

    issue(1, 4'b0001, 2, 20'h77777, 1, 0, nov);
    issue(0, 4'b0000, 2, 20'h77777, 0, 0, nov);
    rst_i = 1;
    exp_q.delete();
    model_clear();
    @(posedge clk_i); #1;
    rst_i = 0;
    repeat (7) begin @(posedge clk_i); #1; end
    rst_i = 1;
    @(posedge clk_i); #1;
    rst_i = 0;
    count_busy("mid_init_rst_busy_cycles");

    flush_i = 1; req_valid_i = 1; req_we_i = 0; req_addr_i = 4'd3; req_tag_i = 20'h0;
    @(negedge clk_i);
    check("ready_with_flush", req_ready_o, 0);
    @(posedge clk_i); #1;
    flush_i = 0; req_valid_i = 0;
    count_busy("flush_req_busy_cycles");
    for (int s = 0; s < NW; s += 5) issue(0, 4'b0000, s, 20'h0, 0, 0, nov);

    repeat (LAT + 2) begin @(posedge clk_i); #1; end
    check("drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/std_nbdcache_tag_array.md
# std_nbdcache_tag_array

Multi-way tag store for the non-blocking data cache, successor to the plain per-way tag SRAM bank. It holds {valid, tag} entries for `WayCount` ways × `NumWords` sets and performs way-parallel tag compare, giving a hit vector. It self-initialises all entries to invalid after reset and on a flush request, and supports a configurable read latency. It sits between the cache controller's lookup/refill logic and the per-way `tc_sram_impl` macros it instantiates.

## Interface
- `NumWords`, 256, number of sets; power of two, ≥2
- `TagWidth`, 44, tag bits per entry (entry width = `TagWidth`+1, MSB is valid)
- `WayCount`, 4, number of ways, 1..16
- `Latency`, 1, accepted read to response, cycles, 1..3
- `SimInit`, "none", passed to SRAM macros
- `AddrWidth`, derived `$clog2(NumWords)`, do not override
- `clk_i` in 1 clock, all logic on rising edge
- `rst_i` in 1 reset; synchronous, active-high
- `flush_i` in 1 one-cycle pulse; invalidate all entries
- `busy_o` out 1 init/flush sequence running
- `req_valid_i` in 1 request valid
- `req_ready_o` out 1 request accepted when valid & ready
- `req_we_i` in 1 1 = write, 0 = lookup
- `req_way_i` in `WayCount` write way mask (one-hot or multi), ignored on lookup
- `req_addr_i` in `AddrWidth` set index
- `req_tag_i` in `TagWidth` compare tag (lookup) / write tag
- `req_vld_i` in 1 valid bit to write
- `rsp_valid_o` out 1 lookup response valid, one cycle
- `rsp_hit_o` out 1 any way valid and tag-equal
- `rsp_hit_way_o` out `WayCount` one-hot, lowest-index hitting way
- `rsp_multi_hit_o` out 1 more than one way hit (error flag)
- `rsp_vld_o` out `WayCount` valid bits of all ways at set
- `rsp_tag_o` out `WayCount*TagWidth` tags of all ways, way i at [i*TagWidth +: TagWidth]

## Operation
- FSM states: INIT, IDLE. Reset → INIT with set counter 0. flush_i in IDLE → INIT, counter 0.
- INIT: each cycle writes entry 0 to all ways at set = counter, counter++. After set `NumWords`-1 is written → IDLE. Takes exactly `NumWords` cycles. `busy_o`=1, `req_ready_o`=0 throughout.
- flush_i during INIT: counter restarts at 0.
- IDLE: `req_ready_o`=1 unless flush_i is high that cycle (flush wins, request not accepted).
- Write: ways in `req_way_i` get {`req_vld_i`, `req_tag_i`} at `req_addr_i`. Other ways are not enabled. No response.
- Lookup: all ways read at `req_addr_i`. Tag compare is on the registered tag, aligned with SRAM data. hit_i = vld_i & (tag_i == req_tag). `rsp_hit_way_o` is priority-encoded lowest index. `rsp_multi_hit_o` = popcount(hits) > 1.
- Lookups accepted before a flush still return responses with pre-flush data.
- Per-way `tc_sram_impl` is used at Latency 1. Latency-1 extra register stages are placed on rdata and on the compare tag/valid pipeline. Compare logic sits after the final stage.

## Timing
- Reset values: `busy_o`=1, `req_ready_o`=0, `rsp_valid_o`=0, `rsp_hit_o`=0, `rsp_hit_way_o`=0, `rsp_multi_hit_o`=0, `rsp_vld_o`=0, `rsp_tag_o`=0.
- Response data outputs hold their last value when `rsp_valid_o`=0. Only `rsp_valid_o` is qualified.
- Lookup accepted at cycle t → `rsp_valid_o`=1 at t+`Latency`. Fully pipelined: one lookup per cycle, no backpressure on response.
- Write at cycle t, lookup of same set at t+1 → sees the new data.
- Write and lookup are never simultaneous (single port). A write is a single request.
- `busy_o` falls in the cycle after the last INIT write. `req_ready_o` rises in the same cycle.
- `rst_i` mid-INIT or with lookups in flight: pipeline valids cleared, INIT restarts from set 0.

## Test plan
- Reset, then a 16-set / 4-way / TagWidth 20 / Latency 2 config → `busy_o`=1 for 16 cycles, ready at cycle 17. A lookup of every set gives hit=0, vld=0000.
- Write way 2, set 5, tag 0xABCDE, vld=1; lookup set 5 tag 0xABCDE next cycle → 2 cycles later hit=1, hit_way=0100, multi_hit=0. Lookup with tag 0xABCDF → hit=0, rsp_tag way2=0xABCDE.
- Write the same tag 0x12345 to ways 0 and 3 (mask 1001), set 9; lookup → hit_way=0001, multi_hit=1, vld=1001.
- Write vld=0, tag 0x11111 to way 1; lookup 0x11111 → hit=0.
- Back-to-back lookups on sets 0..15 with no bubbles → 16 consecutive `rsp_valid_o` pulses in order. Then assert flush_i with 2 lookups in flight → both respond with old data, busy 16 cycles, all entries invalid afterwards.
- Assert `rst_i` at INIT cycle 7 → INIT restarts, busy for 16 more cycles. Try flush_i on an IDLE cycle together with a request → request not accepted.
